// File: rtl/board_serializer_if.sv
`default_nettype none
// ============================================================================
// board_serializer_if : solver / uart_tx handshake bundle for board_serializer
// Rev 1.0
// ============================================================================
interface board_serializer_if #(
  parameter int N_MAX = 11,
  parameter int M_MAX = 11
);
  logic                     start;
  logic [M_MAX*N_MAX-1:0]   board;
  logic [3:0]               n;
  logic [3:0]               m;
  logic                     tx_done;
  logic                     axiov;
  logic [7:0]               axiod;
  logic                     busy;
  logic                     done;

  modport master (
    output start, board, n, m, tx_done,
    input  axiov, axiod, busy, done
  );

  modport slave (
    input  start, board, n, m, tx_done,
    output axiov, axiod, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/board_serializer.sv
`default_nettype none
// ============================================================================
// board_serializer : latches a solved board and streams header + packed rows
// Rev 1.0
// ============================================================================
module board_serializer #(
  parameter int N_MAX = 11,
  parameter int M_MAX = 11
) (
  input  logic               clk,
  input  logic               rst,
  board_serializer_if.slave  bus
);
  localparam int CELLS     = M_MAX * N_MAX;
  localparam int ROW_BYTES = (N_MAX + 7) / 8;
  localparam int BW        = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int IW        = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic             hdr_q, hdr_d;
  logic [CELLS-1:0] board_q, board_d;
  logic [3:0]       n_q, n_d;
  logic [3:0]       m_q, m_d;

  logic [7:0]       cur_byte;
  logic             last_byte;
  int               col;
  int               idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      byte_q  <= '0;
      hdr_q   <= 1'b0;
      board_q <= '0;
      n_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      byte_q  <= byte_d;
      hdr_q   <= hdr_d;
      board_q <= board_d;
      n_q     <= n_d;
      m_q     <= m_d;
    end
  end

  // Byte under the pointer; columns at or beyond n_q read as 0.
  always_comb begin
    cur_byte = 8'h00;
    col      = 0;
    idx      = 0;
    if (hdr_q) begin
      cur_byte = {n_q, m_q};
    end else begin
      for (int j = 0; j < 8; j++) begin
        col = 8 * int'(byte_q) + j;
        idx = int'(row_q) * N_MAX + col;
        if (col < int'(n_q) && idx < CELLS) begin
          cur_byte[j] = board_q[IW'(idx)];
        end
      end
    end
  end

  assign last_byte = hdr_q ? (m_q == 4'd0)
                           : ((row_q == m_q - 4'd1) && (byte_q == BW'(ROW_BYTES - 1)));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    byte_d  = byte_q;
    hdr_d   = hdr_q;
    board_d = board_q;
    n_d     = n_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SEND;
          hdr_d   = 1'b1;
          row_d   = '0;
          byte_d  = '0;
          board_d = bus.board;
          n_d     = (int'(bus.n) > N_MAX) ? 4'(N_MAX) : bus.n;
          m_d     = (int'(bus.m) > M_MAX) ? 4'(M_MAX) : bus.m;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bus.tx_done) begin
          if (last_byte) begin
            state_d = FINISH;
          end else begin
            state_d = SEND;
            if (hdr_q) begin
              hdr_d = 1'b0;
            end else if (byte_q == BW'(ROW_BYTES - 1)) begin
              byte_d = '0;
              row_d  = row_q + 4'd1;
            end else begin
              byte_d = byte_q + BW'(1);
            end
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.axiov = (state_q == SEND);
  assign bus.axiod = (state_q == SEND || state_q == WAIT) ? cur_byte : 8'h00;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == FINISH);
endmodule
`default_nettype wire
